// File: rtl/mcp_controller.sv
// Multicycle MIPS control unit: Moore state sequencer plus ALU decoder.
// Drives every datapath select and enable for lw, sw, R-type, beq, addi and j.
module mcp_controller (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] op_i6,
    input  logic [5:0] funct_i6,
    input  logic       zero_i,
    output logic       iord_o,
    output logic       memwrite_o,
    output logic       irwrite_o,
    output logic       regdst_o,
    output logic       memtoreg_o,
    output logic       regwrite_o,
    output logic       alusrca_o,
    output logic [1:0] alusrcb_o2,
    output logic [1:0] pcsrc_o2,
    output logic       pcen_o,
    output logic [2:0] alucontrol_o3,
    output logic [3:0] state_o4
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     state;
    state_t     next_state;
    state_t     out_state;
    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic [1:0] aluop;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= FETCH;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:   next_state = DECODE;
            DECODE: begin
                case (op_i6)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JUMP;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR:  next_state = (op_i6 == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   next_state = MEMWB;
            EXECUTE: next_state = ALUWB;
            ADDIEX:  next_state = ADDIWB;
            default: next_state = FETCH;
        endcase
    end

    // Outputs decode from FETCH while reset is held so the datapath sees a
    // clean fetch setup, with every write enable suppressed below.
    always_comb begin
        out_state     = rst_i ? FETCH : state;
        iord_o        = 1'b0;
        memwrite      = 1'b0;
        irwrite       = 1'b0;
        regdst_o      = 1'b0;
        memtoreg_o    = 1'b0;
        regwrite      = 1'b0;
        alusrca_o     = 1'b0;
        alusrcb_o2    = 2'b00;
        pcsrc_o2      = 2'b00;
        pcwrite       = 1'b0;
        branch        = 1'b0;
        aluop         = 2'b00;
        case (out_state)
            FETCH: begin
                alusrcb_o2 = 2'b01;
                irwrite    = 1'b1;
                pcwrite    = 1'b1;
            end
            DECODE:  alusrcb_o2 = 2'b11;
            MEMADR: begin
                alusrca_o  = 1'b1;
                alusrcb_o2 = 2'b10;
            end
            MEMRD:   iord_o = 1'b1;
            MEMWB: begin
                memtoreg_o = 1'b1;
                regwrite   = 1'b1;
            end
            MEMWR: begin
                iord_o   = 1'b1;
                memwrite = 1'b1;
            end
            EXECUTE: begin
                alusrca_o = 1'b1;
                aluop     = 2'b10;
            end
            ALUWB: begin
                regdst_o = 1'b1;
                regwrite = 1'b1;
            end
            BRANCH: begin
                alusrca_o = 1'b1;
                aluop     = 2'b01;
                pcsrc_o2  = 2'b01;
                branch    = 1'b1;
            end
            ADDIEX: begin
                alusrca_o  = 1'b1;
                alusrcb_o2 = 2'b10;
            end
            ADDIWB:  regwrite = 1'b1;
            JUMP: begin
                pcsrc_o2 = 2'b10;
                pcwrite  = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_o4   = out_state;
    assign irwrite_o  = irwrite & ~rst_i;
    assign memwrite_o = memwrite & ~rst_i;
    assign regwrite_o = regwrite & ~rst_i;
    assign pcen_o     = (pcwrite | (branch & zero_i)) & ~rst_i;

    always_comb begin
        alucontrol_o3 = 3'b010;
        case (aluop)
            2'b01: alucontrol_o3 = 3'b110;
            2'b10: begin
                case (funct_i6)
                    6'b100010: alucontrol_o3 = 3'b110;
                    6'b100100: alucontrol_o3 = 3'b000;
                    6'b100101: alucontrol_o3 = 3'b001;
                    6'b101010: alucontrol_o3 = 3'b111;
                    default:   alucontrol_o3 = 3'b010;
                endcase
            end
            default: alucontrol_o3 = 3'b010;
        endcase
    end

endmodule
